// File: rtl/keypad_emulator_pkg.sv
// Shared state type, keypad geometry and key-code field helpers for the keypad emulator.
package keypad_pkg;

  localparam int KP_ROWS = 4;
  localparam int KP_COLS = 4;

  typedef enum logic [1:0] {
    KP_IDLE           = 2'd0,
    KP_BOUNCE_PRESS   = 2'd1,
    KP_HELD           = 2'd2,
    KP_BOUNCE_RELEASE = 2'd3
  } kp_state_t;

  function automatic logic [1:0] kp_row(input logic [3:0] code);
    return code[3:2];
  endfunction

  function automatic logic [1:0] kp_col(input logic [3:0] code);
    return code[1:0];
  endfunction

endpackage

// File: rtl/keypad_emulator_if.sv
// Press-request handshake and contact status between a requester and the keypad emulator.
// press_valid/press_ready: a request transfers on a rising clk edge where both are high;
// key_code must be stable while press_valid is high, and press_valid is never queued.
interface keypad_emulator_if;
  logic [3:0] key_code;
  logic       press_valid;
  logic       press_ready;
  logic       key_down;
  logic       press_done;

  modport master (
    output key_code, press_valid,
    input  press_ready, key_down, press_done
  );

  modport slave (
    input  key_code, press_valid,
    output press_ready, key_down, press_done
  );
endinterface

// File: rtl/keypad_emulator_kp_phase_timer.sv
// Phase timer: counts period-long slots, toggles the contact level per slot and flags the last slot.
// Toggle counting exists only when KEYPAD_EMULATOR_BOUNCE_EN is defined.
module kp_phase_timer #(
  parameter int CW = 1,
  parameter int TW = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_start,
  input  logic [CW-1:0] i_period,
  input  logic [TW-1:0] i_toggles,
  input  logic          i_init_level,
  output logic          o_done,
  output logic          o_level
);

  logic [CW-1:0] r_cnt;
  logic          w_period_end;

  assign w_period_end = (r_cnt == i_period - CW'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_start || w_period_end) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

`ifdef KEYPAD_EMULATOR_BOUNCE_EN
  logic [TW-1:0] r_tog;
  logic          r_level;

  // A start always wins over a slot boundary so each phase begins from its own initial level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tog   <= '0;
      r_level <= 1'b0;
    end else if (i_start) begin
      r_tog   <= '0;
      r_level <= i_init_level;
    end else if (w_period_end) begin
      r_tog   <= r_tog + TW'(1);
      r_level <= ~r_level;
    end
  end

  assign o_done  = w_period_end && (r_tog == i_toggles - TW'(1));
  assign o_level = r_level;
`else
  logic w_unused;
  assign w_unused = ^{i_toggles, i_init_level};
  assign o_done   = w_period_end;
  assign o_level  = 1'b0;
`endif

endmodule

// File: rtl/keypad_emulator.sv
// Keypad emulator: plays one key press (optionally with contact bounce) onto a scanned row/column matrix.
// Bounce phases are compiled in only when KEYPAD_EMULATOR_BOUNCE_EN is defined.
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int HOLD_CYCLES    = 1_000_000,
  parameter int BOUNCE_PERIOD  = 5_000,
  parameter int BOUNCE_TOGGLES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [KP_COLS-1:0] col_n,
  output logic [KP_ROWS-1:0] row_n,
  keypad_emulator_if.slave   bus,
  output kp_state_t          o_dbg_state
);

  localparam int HOLD_EFF = (HOLD_CYCLES < 1) ? 1 : HOLD_CYCLES;
  localparam int PER_EFF  = (BOUNCE_PERIOD < 1) ? 1 : BOUNCE_PERIOD;
  localparam int TOG_EFF  = (BOUNCE_TOGGLES < 1) ? 1 : BOUNCE_TOGGLES;
  localparam int MAX_P    = (HOLD_EFF > PER_EFF) ? HOLD_EFF : PER_EFF;
  localparam int CW       = $clog2(MAX_P + 1);
  localparam int TW       = $clog2(TOG_EFF + 1);
  localparam logic [CW-1:0] HOLD_P = HOLD_EFF[CW-1:0];
  localparam logic [CW-1:0] PER_P  = PER_EFF[CW-1:0];
  localparam logic [TW-1:0] TOG_P  = TOG_EFF[TW-1:0];

`ifdef KEYPAD_EMULATOR_BOUNCE_EN
  localparam kp_state_t PRESS_ENTRY = KP_BOUNCE_PRESS;
  localparam kp_state_t HOLD_EXIT   = KP_BOUNCE_RELEASE;
`else
  localparam kp_state_t PRESS_ENTRY = KP_HELD;
  localparam kp_state_t HOLD_EXIT   = KP_IDLE;
`endif

  kp_state_t          r_state;
  kp_state_t          w_next;
  logic [3:0]         r_key;
  logic [KP_ROWS-1:0] r_row_n;
  logic               r_key_down;
  logic               r_busy;
  logic               r_press_done;

  logic               w_accept;
  logic               w_start;
  logic               w_done;
  logic               w_level;
  logic               w_contact;
  logic               w_init_level;
  logic               w_col_hit;
  logic [1:0]         w_row;
  logic [CW-1:0]      w_period;
  logic [TW-1:0]      w_toggles;

  assign bus.press_ready = rst_n && (r_state == KP_IDLE);
  assign w_accept        = bus.press_valid && bus.press_ready;
  assign w_start         = (w_next != r_state);
  assign w_init_level    = (w_next == KP_BOUNCE_PRESS);
  assign w_row           = kp_row(r_key);
  assign w_col_hit       = !col_n[kp_col(r_key)];

  kp_phase_timer #(
    .CW (CW),
    .TW (TW)
  ) u_timer (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_start      (w_start),
    .i_period     (w_period),
    .i_toggles    (w_toggles),
    .i_init_level (w_init_level),
    .o_done       (w_done),
    .o_level      (w_level)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= KP_IDLE;
      r_key   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) r_key <= bus.key_code;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_contact = 1'b0;
    w_period  = PER_P;
    w_toggles = TOG_P;
    case (r_state)
      KP_IDLE: begin
        if (w_accept) w_next = PRESS_ENTRY;
      end
      KP_BOUNCE_PRESS: begin
        w_contact = w_level;
        if (w_done) w_next = KP_HELD;
      end
      KP_HELD: begin
        w_contact = 1'b1;
        w_period  = HOLD_P;
        w_toggles = TW'(1);
        if (w_done) w_next = HOLD_EXIT;
      end
      KP_BOUNCE_RELEASE: begin
        w_contact = w_level;
        if (w_done) w_next = KP_IDLE;
      end
      default: w_next = KP_IDLE;
    endcase
  end

  // press_done lines up with the first registered-open cycle after a sequence; reset clears r_busy so aborts never pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_row_n      <= '1;
      r_key_down   <= 1'b0;
      r_busy       <= 1'b0;
      r_press_done <= 1'b0;
    end else begin
      r_key_down   <= w_contact;
      r_busy       <= (r_state != KP_IDLE);
      r_press_done <= r_busy && (r_state == KP_IDLE);
      for (int r = 0; r < KP_ROWS; r++) begin
        r_row_n[r] <= !(w_contact && w_col_hit && (w_row == 2'(r)));
      end
    end
  end

  assign row_n          = r_row_n;
  assign bus.key_down   = r_key_down;
  assign bus.press_done = r_press_done;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_keypad_emulator.sv
// Directed bench for keypad_emulator with HOLD_CYCLES=8, BOUNCE_PERIOD=2, BOUNCE_TOGGLES=4 and a rotating column scan.
`timescale 1ns/1ps
module tb_keypad_emulator;
  import keypad_pkg::*;

  localparam int HOLD = 8;
  localparam int PER  = 2;
  localparam int TOG  = 4;
`ifdef KEYPAD_EMULATOR_BOUNCE_EN
  localparam int PRE  = PER * TOG;
`else
  localparam int PRE  = 0;
`endif

  logic       clk;
  logic       rst_n;
  logic [3:0] col_n;
  logic [3:0] row_n;
  logic       scan_en;
  kp_state_t  dbg_state;

  int errors = 0;
  int checks = 0;
  logic [0:0] exp_q[$];

  keypad_emulator_if kp_if();

  keypad_emulator #(
    .HOLD_CYCLES    (HOLD),
    .BOUNCE_PERIOD  (PER),
    .BOUNCE_TOGGLES (TOG)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .col_n       (col_n),
    .row_n       (row_n),
    .bus         (kp_if),
    .o_dbg_state (dbg_state)
  );

  // ---- clock / reset / scanner ----
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    #1;
    if (scan_en) col_n = {col_n[2:0], col_n[3]};
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected key_down level after each edge following acceptance.
  task automatic build_exp();
`ifdef KEYPAD_EMULATOR_BOUNCE_EN
    exp_q = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,
              1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
              1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
`else
    exp_q = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`endif
  endtask

  // ---- tests ----
  task automatic test_reset();
    rst_n = 1'b0;
    kp_if.press_valid = 1'b0;
    kp_if.key_code = 4'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (row_n !== 4'hF) begin errors++; $display("FAIL reset_row_n: got %h expected %h", row_n, 4'hF); end
    checks++;
    if (kp_if.key_down !== 1'b0) begin errors++; $display("FAIL reset_key_down: got %b expected 0", kp_if.key_down); end
    checks++;
    if (kp_if.press_done !== 1'b0) begin errors++; $display("FAIL reset_press_done: got %b expected 0", kp_if.press_done); end
    checks++;
    if (dbg_state !== KP_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, KP_IDLE); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (kp_if.press_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", kp_if.press_ready); end
  endtask

  task automatic test_single_press();
    logic [3:0] c;
    logic [3:0] er;
    logic       kd;
    int         n;
    build_exp();
    n = exp_q.size();
    checks++;
    if (kp_if.press_ready !== 1'b1) begin errors++; $display("FAIL single_ready_before: got %b expected 1", kp_if.press_ready); end
    kp_if.key_code = 4'h6;
    kp_if.press_valid = 1'b1;
    @(posedge clk);
    #1 kp_if.press_valid = 1'b0;
    for (int k = 0; k <= n + 1; k++) begin
      @(posedge clk);
      c = col_n;
      @(negedge clk);
      kd = (k < n) ? exp_q[k] : 1'b0;
      er = 4'hF;
      if (kd && !c[2]) er[1] = 1'b0;
      checks++;
      if (kp_if.key_down !== kd) begin errors++; $display("FAIL single_key_down[%0d]: got %b expected %b", k, kp_if.key_down, kd); end
      checks++;
      if (row_n !== er) begin errors++; $display("FAIL single_row_n[%0d]: got %b expected %b (col_n %b)", k, row_n, er, c); end
      checks++;
      if (kp_if.press_done !== (k == n)) begin errors++; $display("FAIL single_press_done[%0d]: got %b expected %b", k, kp_if.press_done, (k == n)); end
      checks++;
      if (kp_if.press_ready !== (k >= n - 1)) begin errors++; $display("FAIL single_ready[%0d]: got %b expected %b", k, kp_if.press_ready, (k >= n - 1)); end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] c;
    logic [3:0] er;
    logic       kd;
    logic       dn;
    logic       rdy;
    int         n;
    int         j;
    int         row_i;
    int         col_i;
    build_exp();
    n = exp_q.size();
    kp_if.key_code = 4'h3;
    kp_if.press_valid = 1'b1;
    @(posedge clk);
    #1 kp_if.key_code = 4'hA;
    for (int k = 0; k <= 2 * n + 2; k++) begin
      @(posedge clk);
      c = col_n;
      if (k == n) #1 kp_if.press_valid = 1'b0;
      @(negedge clk);
      row_i = 0;
      col_i = 3;
      if (k < n) begin
        kd = exp_q[k]; dn = 1'b0; rdy = (k == n - 1);
      end else if (k == n) begin
        kd = 1'b0; dn = 1'b1; rdy = 1'b0;
      end else begin
        j = k - n - 1;
        row_i = 2;
        col_i = 2;
        kd = (j < n) ? exp_q[j] : 1'b0;
        dn = (j == n);
        rdy = (j >= n - 1);
      end
      er = 4'hF;
      if (kd && !c[col_i]) er[row_i] = 1'b0;
      checks++;
      if (kp_if.key_down !== kd) begin errors++; $display("FAIL b2b_key_down[%0d]: got %b expected %b", k, kp_if.key_down, kd); end
      checks++;
      if (row_n !== er) begin errors++; $display("FAIL b2b_row_n[%0d]: got %b expected %b (col_n %b)", k, row_n, er, c); end
      checks++;
      if (kp_if.press_done !== dn) begin errors++; $display("FAIL b2b_press_done[%0d]: got %b expected %b", k, kp_if.press_done, dn); end
      checks++;
      if (kp_if.press_ready !== rdy) begin errors++; $display("FAIL b2b_ready[%0d]: got %b expected %b", k, kp_if.press_ready, rdy); end
    end
  endtask

  task automatic test_all_cols();
    logic [3:0] er;
    logic       kd;
    int         n;
    build_exp();
    n = exp_q.size();
    scan_en = 1'b0;
    col_n = 4'b0000;
    kp_if.key_code = 4'h9;
    kp_if.press_valid = 1'b1;
    @(posedge clk);
    #1 kp_if.press_valid = 1'b0;
    for (int k = 0; k <= n + 1; k++) begin
      @(posedge clk);
      @(negedge clk);
      kd = (k < n) ? exp_q[k] : 1'b0;
      er = kd ? 4'b1011 : 4'hF;
      checks++;
      if (row_n !== er) begin errors++; $display("FAIL allcols_row_n[%0d]: got %b expected %b", k, row_n, er); end
      checks++;
      if (kp_if.press_done !== (k == n)) begin errors++; $display("FAIL allcols_press_done[%0d]: got %b expected %b", k, kp_if.press_done, (k == n)); end
    end
    col_n = 4'b1110;
    scan_en = 1'b1;
  endtask

  task automatic test_reset_mid();
    logic kd;
    int   n;
    build_exp();
    n = exp_q.size();
    kp_if.key_code = 4'h5;
    kp_if.press_valid = 1'b1;
    @(posedge clk);
    #1 kp_if.press_valid = 1'b0;
    for (int k = 0; k <= PRE + 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      kd = exp_q[k];
      checks++;
      if (kp_if.key_down !== kd) begin errors++; $display("FAIL midrst_key_down[%0d]: got %b expected %b", k, kp_if.key_down, kd); end
    end
    checks++;
    if (dbg_state !== KP_HELD) begin errors++; $display("FAIL midrst_state_held: got %0d expected %0d", dbg_state, KP_HELD); end
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (row_n !== 4'hF) begin errors++; $display("FAIL midrst_row_n: got %b expected 1111", row_n); end
    checks++;
    if (kp_if.key_down !== 1'b0) begin errors++; $display("FAIL midrst_key_down: got %b expected 0", kp_if.key_down); end
    checks++;
    if (dbg_state !== KP_IDLE) begin errors++; $display("FAIL midrst_state: got %0d expected %0d", dbg_state, KP_IDLE); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k <= n + 2; k++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (kp_if.press_done !== 1'b0) begin errors++; $display("FAIL midrst_no_done[%0d]: got %b expected 0", k, kp_if.press_done); end
      checks++;
      if (kp_if.key_down !== 1'b0) begin errors++; $display("FAIL midrst_idle_key_down[%0d]: got %b expected 0", k, kp_if.key_down); end
      checks++;
      if (kp_if.press_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready[%0d]: got %b expected 1", k, kp_if.press_ready); end
    end
  endtask

  // ---- sequence and report ----
  initial begin
    col_n = 4'b1110;
    scan_en = 1'b1;
    rst_n = 1'b0;
    kp_if.press_valid = 1'b0;
    kp_if.key_code = 4'h0;
    test_reset();
    test_single_press();
    test_back_to_back();
    test_all_cols();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
